// File: rtl/dbuf_pingpong_ctrl.sv
// Ping-pong sample buffer sequencer: one bank fills from the input stream while the
// other drains to the FIR, with per-bank state, addresses and the output handshake.
module dbuf_pingpong_ctrl #(
  parameter int unsigned FRAME_LEN = 512,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         mem_wr_en,
  output logic                         mem_wr_bank,
  output logic [$clog2(FRAME_LEN)-1:0] mem_wr_addr,
  output logic                         mem_rd_en,
  output logic                         mem_rd_bank,
  output logic [$clog2(FRAME_LEN)-1:0] mem_rd_addr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic [CNT_W-1:0]             frames_in,
  output logic [CNT_W-1:0]             frames_out
);

  localparam int unsigned ADDR_W = $clog2(FRAME_LEN);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } bank_state_e;

  bank_state_e       bank_q [2];
  bank_state_e       bank_d [2];
  logic              wb_q, wb_d;
  logic              rb_q, rb_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [CNT_W-1:0]  frames_in_q, frames_in_d;
  logic [CNT_W-1:0]  frames_out_q, frames_out_d;

  logic wr_fire;
  logic rd_avail;
  logic rd_go;

  // Writer and reader can never act on the same bank in one cycle: the writer
  // only sees EMPTY/FILL banks and the reader only FULL/DRAIN banks.
  assign in_ready = (bank_q[wb_q] == EMPTY) || (bank_q[wb_q] == FILL);
  assign wr_fire  = in_valid & in_ready;
  assign rd_avail = (bank_q[rb_q] == FULL) || (bank_q[rb_q] == DRAIN);
  assign rd_go    = (~out_valid_q | out_ready) & rd_avail;

  assign mem_wr_en   = wr_fire;
  assign mem_wr_bank = wb_q;
  assign mem_wr_addr = wr_addr_q;
  assign mem_rd_en   = rd_go;
  assign mem_rd_bank = rb_q;
  assign mem_rd_addr = rd_addr_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign frames_in   = frames_in_q;
  assign frames_out  = frames_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        bank_q[i] <= EMPTY;
      end
      wb_q         <= 1'b0;
      rb_q         <= 1'b0;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frames_in_q  <= '0;
      frames_out_q <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        bank_q[i] <= bank_d[i];
      end
      wb_q         <= wb_d;
      rb_q         <= rb_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      frames_in_q  <= frames_in_d;
      frames_out_q <= frames_out_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      bank_d[i] = bank_q[i];
    end
    wb_d         = wb_q;
    rb_d         = rb_q;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    frames_in_d  = frames_in_q;
    frames_out_d = frames_out_q;

    for (int unsigned i = 0; i < 2; i++) begin
      if (wr_fire && (wb_q == i[0])) begin
        bank_d[i] = (wr_addr_q == LAST_ADDR) ? FULL : FILL;
      end
      // A bank freed here only becomes visible to the writer next cycle.
      if (rd_go && (rb_q == i[0])) begin
        bank_d[i] = (rd_addr_q == LAST_ADDR) ? EMPTY : DRAIN;
      end
    end

    if (wr_fire) begin
      if (wr_addr_q == LAST_ADDR) begin
        wr_addr_d   = '0;
        wb_d        = ~wb_q;
        frames_in_d = frames_in_q + 1'b1;
      end else begin
        wr_addr_d = wr_addr_q + 1'b1;
      end
    end

    if (rd_go) begin
      if (rd_addr_q == LAST_ADDR) begin
        rd_addr_d    = '0;
        rb_d         = ~rb_q;
        frames_out_d = frames_out_q + 1'b1;
      end else begin
        rd_addr_d = rd_addr_q + 1'b1;
      end
    end

    out_valid_d = rd_go | (out_valid_q & ~out_ready);
    // out_last tracks the sample held in the memory output register.
    if (rd_go) begin
      out_last_d = (rd_addr_q == LAST_ADDR);
    end else if (out_ready) begin
      out_last_d = 1'b0;
    end

    if (flush) begin
      for (int unsigned i = 0; i < 2; i++) begin
        bank_d[i] = EMPTY;
      end
      wb_d         = 1'b0;
      rb_d         = 1'b0;
      wr_addr_d    = '0;
      rd_addr_d    = '0;
      out_valid_d  = 1'b0;
      out_last_d   = 1'b0;
      frames_in_d  = '0;
      frames_out_d = '0;
    end
  end

endmodule
